// File: rtl/fuzzy_pkg.sv
// Shared types and constants for the fuzzy PWM speed controller:
// FSM encoding, membership breakpoints, default singletons and the rule table.
package fuzzy_pkg;

  localparam int unsigned G_W       = 8;
  localparam int unsigned DEN_W     = 11;
  localparam int unsigned NUM_W     = 20;
  localparam int unsigned RULE_CNT  = 9;
  localparam int unsigned DIV_ITERS = 20;

  localparam int unsigned MF_LO_FLAT   = 45;
  localparam int unsigned MF_MID_START = 63;
  localparam int unsigned MF_LO_ZERO   = 109;
  localparam int unsigned MF_PEAK      = 127;
  localparam int unsigned MF_MID_ZERO  = 191;
  localparam int unsigned MF_HI_FLAT   = 209;
  localparam int unsigned MF_SLOPE     = 4;

  localparam int unsigned MF_LO_ICPT   = MF_SLOPE * MF_LO_ZERO;
  localparam int unsigned MF_MID_ICPT  = MF_SLOPE * MF_MID_START;
  // Falling edge of mid and rising edge of hi share this intercept
  localparam int unsigned MF_FALL_ICPT = 763;

  localparam logic [7:0] S_STOP_DEF  = 8'd119;
  localparam logic [7:0] S_SLOW_DEF  = 8'd153;
  localparam logic [7:0] S_MED_DEF   = 8'd187;
  localparam logic [7:0] S_FAST_DEF  = 8'd221;
  localparam logic [7:0] S_BLAST_DEF = 8'd255;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_FUZZ = 3'd1;
  localparam state_t ST_RULE = 3'd2;
  localparam state_t ST_AGG  = 3'd3;
  localparam state_t ST_SUM  = 3'd4;
  localparam state_t ST_DIV  = 3'd5;
  localparam state_t ST_DONE = 3'd6;

  typedef enum logic [1:0] {G_LO = 2'd0, G_MID = 2'd1, G_HI = 2'd2} grade_sel_e;
  typedef enum logic [2:0] {C_STOP = 3'd0, C_SLOW = 3'd1, C_MED = 3'd2,
                            C_FAST = 3'd3, C_BLAST = 3'd4} out_cls_e;

  typedef struct packed {
    grade_sel_e t_sel;
    grade_sel_e l_sel;
    out_cls_e   cls;
  } rule_t;

  // One rule per (t grade, l grade) pair; each feeds one output class
  function automatic rule_t rule_map(input logic [3:0] idx);
    rule_t r;
    case (idx)
      4'd0:    r = '{G_LO,  G_LO,  C_STOP};
      4'd1:    r = '{G_LO,  G_MID, C_STOP};
      4'd2:    r = '{G_LO,  G_HI,  C_SLOW};
      4'd3:    r = '{G_MID, G_LO,  C_SLOW};
      4'd4:    r = '{G_MID, G_MID, C_MED};
      4'd5:    r = '{G_MID, G_HI,  C_FAST};
      4'd6:    r = '{G_HI,  G_LO,  C_FAST};
      4'd7:    r = '{G_HI,  G_MID, C_BLAST};
      default: r = '{G_HI,  G_HI,  C_BLAST};
    endcase
    return r;
  endfunction

  function automatic logic [7:0] sat8(input logic signed [11:0] v);
    if (v < 12'sd0)   return 8'h00;
    if (v > 12'sd255) return 8'hFF;
    return v[7:0];
  endfunction

endpackage

// File: rtl/fuzzy_pwm_core_if.sv
// Request/result bundle of the fuzzy PWM core.
interface fuzzy_pwm_core_if #(parameter int unsigned W = 8);
  logic         start;
  logic [W-1:0] t;
  logic [W-1:0] l;
  logic         busy;
  logic         done;
  logic [7:0]   pw;
  logic         den_zero;
  logic         pwm_out;

  modport master (output start, t, l, input busy, done, pw, den_zero, pwm_out);
  modport slave  (input start, t, l, output busy, done, pw, den_zero, pwm_out);
endinterface

// File: rtl/fuzzy_mf.sv
// Combinational lo/mid/hi membership grades of one 8-bit sample, saturated to 0..255.
module fuzzy_mf
  import fuzzy_pkg::*;
(
  input  logic [7:0] x,
  output logic [7:0] lo_c,
  output logic [7:0] mid_c,
  output logic [7:0] hi_c
);
  logic signed [11:0] x4;

  always_comb begin
    x4    = $signed(12'(x) * 12'(MF_SLOPE));
    lo_c  = 8'h00;
    mid_c = 8'h00;
    hi_c  = 8'h00;

    if (x < 8'(MF_LO_FLAT))       lo_c = 8'hFF;
    else if (x <= 8'(MF_LO_ZERO)) lo_c = sat8($signed(12'(MF_LO_ICPT)) - x4);

    if (x == 8'(MF_PEAK))                                  mid_c = 8'hFF;
    else if (x >= 8'(MF_MID_START) && x < 8'(MF_PEAK))     mid_c = sat8(x4 - $signed(12'(MF_MID_ICPT)));
    else if (x > 8'(MF_PEAK) && x <= 8'(MF_MID_ZERO))      mid_c = sat8($signed(12'(MF_FALL_ICPT)) - x4);

    if (x >= 8'(MF_HI_FLAT))      hi_c = 8'hFF;
    else if (x > 8'(MF_MID_ZERO)) hi_c = sat8(x4 - $signed(12'(MF_FALL_ICPT)));
  end

endmodule

// File: rtl/fuzzy_pwm_core.sv
// Fuzzy fan-speed controller: min/max inference over temperature and light,
// weighted-average defuzzification via serial divider, and a glitch-free PWM.
module fuzzy_pwm_core
  import fuzzy_pkg::*;
#(
  parameter int unsigned W       = 8,
  parameter logic [7:0]  S_STOP  = S_STOP_DEF,
  parameter logic [7:0]  S_SLOW  = S_SLOW_DEF,
  parameter logic [7:0]  S_MED   = S_MED_DEF,
  parameter logic [7:0]  S_FAST  = S_FAST_DEF,
  parameter logic [7:0]  S_BLAST = S_BLAST_DEF,
  parameter bit          PWM_EN  = 1'b1
) (
  input logic             clk,
  input logic             rst,
  fuzzy_pwm_core_if.slave bus
);
  localparam int unsigned N_CLS = 5;
  localparam logic [N_CLS-1:0][7:0] SNG = {S_BLAST, S_FAST, S_MED, S_SLOW, S_STOP};

  state_t                  state_q, state_d;
  logic [3:0]              rule_idx_q, rule_idx_d;
  logic [4:0]              div_cnt_q, div_cnt_d;
  logic [7:0]              t8_q, t8_d, l8_q, l8_d;
  logic [2:0][G_W-1:0]     g_t_q, g_t_d, g_l_q, g_l_d;
  logic [N_CLS-1:0][7:0]   str_q, str_d;
  logic [DEN_W-1:0]        den_q, den_d, rem_q, rem_d;
  logic [NUM_W-1:0]        quo_q, quo_d;
  logic [7:0]              pw_q, pw_d;
  logic                    done_q, done_d, busy_q, busy_d, dz_q, dz_d;
  logic [7:0]              cnt_q, cnt_d, duty_q, duty_d;
  logic                    pwm_q, pwm_d;

  logic [7:0]              t_lo_c, t_mid_c, t_hi_c, l_lo_c, l_mid_c, l_hi_c;
  rule_t                   rule_c;
  logic [7:0]              w_c;
  logic [DEN_W-1:0]        den_sum_c;
  logic [NUM_W-1:0]        num_sum_c;
  logic [DEN_W:0]          trial_c;

  fuzzy_mf u_mf_t (.x(t8_q), .lo_c(t_lo_c), .mid_c(t_mid_c), .hi_c(t_hi_c));
  fuzzy_mf u_mf_l (.x(l8_q), .lo_c(l_lo_c), .mid_c(l_mid_c), .hi_c(l_hi_c));

  // Rule firing strength, aggregate sums and divider trial remainder
  always_comb begin
    rule_c = rule_map(rule_idx_q);
    w_c = (g_t_q[rule_c.t_sel] < g_l_q[rule_c.l_sel]) ? g_t_q[rule_c.t_sel]
                                                      : g_l_q[rule_c.l_sel];
    den_sum_c = '0;
    num_sum_c = '0;
    for (int unsigned i = 0; i < N_CLS; i++) begin
      den_sum_c += DEN_W'(str_q[i]);
      num_sum_c += NUM_W'(SNG[i]) * NUM_W'(str_q[i]);
    end
    trial_c = {rem_q, quo_q[NUM_W-1]};
  end

  always_comb begin
    state_d    = state_q;
    rule_idx_d = rule_idx_q;
    div_cnt_d  = div_cnt_q;
    t8_d       = t8_q;
    l8_d       = l8_q;
    g_t_d      = g_t_q;
    g_l_d      = g_l_q;
    str_d      = str_q;
    den_d      = den_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    pw_d       = pw_q;
    dz_d       = dz_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: if (bus.start) begin
        t8_d    = bus.t[W-1 -: 8];
        l8_d    = bus.l[W-1 -: 8];
        state_d = ST_FUZZ;
      end
      ST_FUZZ: begin
        g_t_d      = {t_hi_c, t_mid_c, t_lo_c};
        g_l_d      = {l_hi_c, l_mid_c, l_lo_c};
        str_d      = '0;
        rule_idx_d = '0;
        state_d    = ST_RULE;
      end
      ST_RULE: begin
        if (w_c > str_q[rule_c.cls]) str_d[rule_c.cls] = w_c;
        if (rule_idx_q == 4'(RULE_CNT - 1)) state_d = ST_AGG;
        else rule_idx_d = rule_idx_q + 4'd1;
      end
      ST_AGG: begin
        den_d   = den_sum_c;
        state_d = ST_SUM;
      end
      ST_SUM: begin
        quo_d     = num_sum_c;
        rem_d     = '0;
        div_cnt_d = '0;
        state_d   = (den_q == '0) ? ST_DONE : ST_DIV;
      end
      ST_DIV: begin
        // Restoring step: quotient bits shift in as dividend bits shift out
        if (trial_c >= {1'b0, den_q}) begin
          rem_d = DEN_W'(trial_c - {1'b0, den_q});
          quo_d = {quo_q[NUM_W-2:0], 1'b1};
        end else begin
          rem_d = trial_c[DEN_W-1:0];
          quo_d = {quo_q[NUM_W-2:0], 1'b0};
        end
        if (div_cnt_q == 5'(DIV_ITERS - 1)) state_d = ST_DONE;
        else div_cnt_d = div_cnt_q + 5'd1;
      end
      ST_DONE: begin
        done_d  = 1'b1;
        dz_d    = (den_q == '0);
        pw_d    = (den_q == '0) ? 8'h00 : quo_q[7:0];
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // Duty is latched only at counter wrap so a period never mixes two duties
  always_comb begin
    cnt_d  = cnt_q + 8'd1;
    duty_d = (cnt_q == 8'hFF) ? pw_q : duty_q;
    pwm_d  = PWM_EN && (cnt_d < duty_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rule_idx_q <= '0;
      div_cnt_q  <= '0;
      t8_q       <= '0;
      l8_q       <= '0;
      g_t_q      <= '0;
      g_l_q      <= '0;
      str_q      <= '0;
      den_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      pw_q       <= '0;
      dz_q       <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      cnt_q      <= '0;
      duty_q     <= '0;
      pwm_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rule_idx_q <= rule_idx_d;
      div_cnt_q  <= div_cnt_d;
      t8_q       <= t8_d;
      l8_q       <= l8_d;
      g_t_q      <= g_t_d;
      g_l_q      <= g_l_d;
      str_q      <= str_d;
      den_q      <= den_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      pw_q       <= pw_d;
      dz_q       <= dz_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
      duty_q     <= duty_d;
      pwm_q      <= pwm_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.pw       = pw_q;
  assign bus.den_zero = dz_q;
  assign bus.pwm_out  = pwm_q;

endmodule

// File: tb/tb_fuzzy_pwm_core.sv
// Randomized bench for fuzzy_pwm_core (W=8 and W=12 instances) against a
// formula-level model of membership, min/max inference and weighted average.
module tb_fuzzy_pwm_core;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fuzzy_pwm_core_if #(.W(8))  bus8 ();
  fuzzy_pwm_core_if #(.W(12)) bus12 ();

  fuzzy_pwm_core #(.W(8))  u_dut8  (.clk(clk), .rst(rst), .bus(bus8));
  fuzzy_pwm_core #(.W(12)) u_dut12 (.clk(clk), .rst(rst), .bus(bus12));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int imin(input int a, input int b); return (a < b) ? a : b; endfunction
  function automatic int imax(input int a, input int b); return (a > b) ? a : b; endfunction
  function automatic int clamp8(input int v); return (v < 0) ? 0 : ((v > 255) ? 255 : v); endfunction

  function automatic int mu_lo(input int x);
    if (x < 45) return 255;
    if (x <= 109) return clamp8(436 - 4 * x);
    return 0;
  endfunction

  function automatic int mu_mid(input int x);
    if (x < 63) return 0;
    if (x <= 126) return clamp8(4 * x - 252);
    if (x == 127) return 255;
    if (x <= 191) return clamp8(763 - 4 * x);
    return 0;
  endfunction

  function automatic int mu_hi(input int x);
    if (x <= 191) return 0;
    if (x <= 208) return clamp8(4 * x - 763);
    return 255;
  endfunction

  function automatic void ref_model(input int t8, input int l8, output int pw, output bit dz);
    int stop, slow, med, fast, blast, num, den;
    blast = imax(imin(mu_hi(t8), mu_hi(l8)), imin(mu_hi(t8), mu_mid(l8)));
    fast  = imax(imin(mu_hi(t8), mu_lo(l8)), imin(mu_mid(t8), mu_hi(l8)));
    med   = imin(mu_mid(t8), mu_mid(l8));
    slow  = imax(imin(mu_mid(t8), mu_lo(l8)), imin(mu_lo(t8), mu_hi(l8)));
    stop  = imax(imin(mu_lo(t8), mu_mid(l8)), imin(mu_lo(t8), mu_lo(l8)));
    den   = stop + slow + med + fast + blast;
    num   = 119 * stop + 153 * slow + 187 * med + 221 * fast + 255 * blast;
    dz    = (den == 0);
    pw    = dz ? 0 : num / den;
  endfunction

  task automatic drive(input bit w12, input bit st, input logic [11:0] tv, input logic [11:0] lv);
    if (w12) begin bus12.start = st; bus12.t = tv; bus12.l = lv; end
    else begin bus8.start = st; bus8.t = tv[7:0]; bus8.l = lv[7:0]; end
  endtask

  function automatic int get_done(input bit w12); return w12 ? int'(bus12.done) : int'(bus8.done); endfunction
  function automatic int get_busy(input bit w12); return w12 ? int'(bus12.busy) : int'(bus8.busy); endfunction
  function automatic int get_pw(input bit w12);   return w12 ? int'(bus12.pw) : int'(bus8.pw); endfunction
  function automatic int get_dz(input bit w12);   return w12 ? int'(bus12.den_zero) : int'(bus8.den_zero); endfunction
  function automatic int get_pwm(input bit w12);  return w12 ? int'(bus12.pwm_out) : int'(bus8.pwm_out); endfunction

  // One request; inputs are scrambled after the sampling edge and start is
  // pulsed while busy and once exactly on the DONE cycle.
  task automatic run_req(input string tag, input bit w12, input logic [11:0] tv,
                         input logic [11:0] lv, input int exp_pw, input bit exp_dz);
    int lat_exp;
    int lat;
    bit st;
    lat_exp = exp_dz ? 13 : 33;
    lat = -1;
    drive(w12, 1'b1, tv, lv);
    @(posedge clk); #1;
    drive(w12, 1'b0, 12'($urandom), 12'($urandom));
    check_eq({tag, ".busy"}, get_busy(w12), 1);
    for (int k = 1; k <= 60; k++) begin
      if (k == lat_exp)     st = 1'b1;
      else if (k < lat_exp) st = 1'($urandom_range(0, 1));
      else                  st = 1'b0;
      drive(w12, st, 12'($urandom), 12'($urandom));
      @(posedge clk); #1;
      if (get_done(w12) != 0) begin
        lat = k;
        break;
      end
    end
    drive(w12, 1'b0, 12'($urandom), 12'($urandom));
    check_eq({tag, ".latency"}, lat, lat_exp);
    check_eq({tag, ".pw"}, get_pw(w12), exp_pw);
    check_eq({tag, ".den_zero"}, get_dz(w12), int'(exp_dz));
    check_eq({tag, ".idle"}, get_busy(w12), 0);
    @(posedge clk); #1;
    check_eq({tag, ".pulse"}, get_done(w12), 0);
    check_eq({tag, ".no_restart"}, get_busy(w12), 0);
  endtask

  task automatic check_pwm(input string tag, input bit w12, input int exp_high);
    int highs;
    highs = 0;
    repeat (260) @(posedge clk);
    repeat (256) begin
      @(posedge clk); #1;
      highs += get_pwm(w12);
    end
    check_eq(tag, highs, exp_high);
  endtask

  initial begin
    int pw_m;
    bit dz_m;
    int done_seen;
    logic [11:0] tv, lv;

    rst = 1'b1;
    drive(1'b0, 1'b0, 12'h0, 12'h0);
    drive(1'b1, 1'b0, 12'h0, 12'h0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset.busy", get_busy(0), 0);
    check_eq("reset.done", get_done(0), 0);
    check_eq("reset.pw", get_pw(0), 0);
    check_eq("reset.den_zero", get_dz(0), 0);
    check_eq("reset.pwm_out", get_pwm(0), 0);
    check_eq("reset.pw12", get_pw(1), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_req("dz_t191", 1'b0, 12'd191, 12'($urandom_range(0, 255)), 0, 1'b1);
    check_pwm("dz_pwm_low", 1'b0, 0);
    run_req("mid_mid", 1'b0, 12'd127, 12'd127, 187, 1'b0);
    run_req("lo_lo", 1'b0, 12'd0, 12'd0, 119, 1'b0);
    run_req("hi_hi", 1'b0, 12'd255, 12'd255, 255, 1'b0);
    run_req("t100_l127", 1'b0, 12'd100, 12'd127, 173, 1'b0);
    check_pwm("pwm_173", 1'b0, 173);

    for (int i = 0; i < 24; i++) begin
      tv = 12'($urandom_range(0, 255));
      lv = 12'($urandom_range(0, 255));
      ref_model(int'(tv), int'(lv), pw_m, dz_m);
      run_req($sformatf("rand%0d", i), 1'b0, tv, lv, pw_m, dz_m);
      if (i % 8 == 0) check_pwm($sformatf("rand%0d.pwm", i), 1'b0, pw_m);
    end

    // Abort a request with reset twenty edges after start
    run_req("pre_abort", 1'b0, 12'd127, 12'd127, 187, 1'b0);
    done_seen = 0;
    drive(1'b0, 1'b1, 12'd127, 12'd127);
    @(posedge clk); #1;
    for (int k = 1; k < 20; k++) begin
      drive(1'b0, 1'($urandom_range(0, 1)), 12'($urandom), 12'($urandom));
      @(posedge clk); #1;
      done_seen += get_done(0);
    end
    drive(1'b0, 1'b0, 12'h0, 12'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      done_seen += get_done(0);
    end
    check_eq("abort.done_seen", done_seen, 0);
    check_eq("abort.pw", get_pw(0), 0);
    check_eq("abort.busy", get_busy(0), 0);
    run_req("abort.recover", 1'b0, 12'd0, 12'd0, 119, 1'b0);

    run_req("w12_7f0", 1'b1, 12'h7F0, 12'h7F0, 187, 1'b0);
    check_pwm("w12_pwm_187", 1'b1, 187);
    for (int i = 0; i < 4; i++) begin
      tv = 12'($urandom);
      lv = 12'($urandom);
      ref_model(int'(tv[11:4]), int'(lv[11:4]), pw_m, dz_m);
      run_req($sformatf("w12_rand%0d", i), 1'b1, tv, lv, pw_m, dz_m);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fuzzy_pwm_core.md
FUZZY_PWM_CORE -- requirements
Module: fuzzy_pwm_core

Interface
REQ-001 Parameter: W, 8, input sample width; legal range W >= 8.
REQ-002 Parameter: S_STOP/S_SLOW/S_MED/S_FAST/S_BLAST, 119/153/187/221/255, 8-bit output singletons.
REQ-003 Parameter: PWM_EN, 1, enables the pwm_out generator; 0 ties pwm_out low.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  reset: synchronous, active-high.
REQ-006 start  in  1  request; sampled only in IDLE.
REQ-007 t  in  W  temperature sample.
REQ-008 l  in  W  light sample.
REQ-009 busy  out  1  high whenever FSM is not IDLE.
REQ-010 done  out  1  one-cycle pulse when pw updates.
REQ-011 pw  out  8  defuzzified duty; held between updates.
REQ-012 den_zero  out  1  set with done when the aggregate weight is 0; cleared at next done.
REQ-013 pwm_out  out  1  PWM at duty pw/256.

Function
REQ-014 Fuzzification SHALL use x8 = x[W-1:W-8] (top 8 bits) of t and l.
REQ-015 Membership grades SHALL be 8-bit and saturate to [0,255]; no wrap-around:
  lo(x)=255 if x<45; clamp(436-4x) for 45..109; else 0.
  mid(x)=0 if x<63; clamp(4x-252) for 63..126; 255 at 127; clamp(763-4x) for 128..191; else 0.
  hi(x)=0 if x<=191; clamp(4x-763) for 192..208; else 255.
REQ-016 Rules SHALL be min(), aggregation max(): blast=max(hi_t^hi_l, hi_t^mid_l); fast=max(hi_t^lo_l, mid_t^hi_l); med=mid_t^mid_l; slow=max(mid_t^lo_l, lo_t^hi_l); stop=max(lo_t^mid_l, lo_t^lo_l).
REQ-017 num SHALL be 20 bits = sum(singleton*grade); den SHALL be 11 bits = sum(grades).
REQ-018 pw SHALL be floor(num/den), computed by a restoring shift-subtract divider of exactly 20 iterations.
REQ-019 FSM states: IDLE, FUZZ, RULE (9 cycles, 4-bit rule index), AGG, SUM, DIV (20 cycles), DONE.
REQ-020 Transitions: IDLE->FUZZ on start; FUZZ->RULE; RULE->AGG at index 8; AGG->SUM; SUM->DIV, or SUM->DONE if den==0; DIV->DONE after iteration 19; DONE->IDLE.
REQ-021 t and l SHALL be registered on the edge that samples start (edge N); later input changes have no effect.
REQ-022 For den!=0, done and the new pw SHALL appear after edge N+33; for den==0, pw=0 and den_zero=1 after edge N+13.
REQ-023 A start while busy SHALL be ignored; a start coincident with DONE SHALL be ignored.
REQ-024 pwm_out SHALL use a free-running 8-bit counter c: pwm_out = (c < pw); pw is applied only when c==255 -> 0 (glitch-free).

Reset
REQ-025 On rst: FSM=IDLE, pw=0, done=0, busy=0, den_zero=0, pwm counter=0, pwm_out=0.
REQ-026 rst mid-operation SHALL abort without a done pulse; pw stays 0 until the next completed request.

Structure
REQ-027 Package fuzzy_pkg SHALL hold the FSM state enum, membership breakpoints (45,63,109,127,191,209), slope 4 and default singletons.
REQ-028 Sub-module fuzzy_mf SHALL be a combinational lo/mid/hi grade evaluator, instantiated once for t and once for l.

Verification
REQ-029 t=127, l=127, start -> done at N+33, pw=187, den_zero=0.
REQ-030 t=0, l=0 -> pw=119; t=255, l=255 -> pw=255.
REQ-031 t=100, l=127 -> stop=36, med=148, num=31960, den=184 -> pw=173.
REQ-032 t=191, any l -> den=0 -> done at N+13, pw=0, den_zero=1; pwm_out stays low.
REQ-033 start pulses during busy, and rst asserted at N+20 -> no done, pw=0; a fresh start with t=l=0 then gives pw=119.
REQ-034 W=12, t=12'h7F0, l=12'h7F0 -> pw=187; then check pwm_out high for 187 of every 256 cycles.
